mandel_view_ctrl: RTL

Viewport controller for the Mandelbrot iterator chain. It sits between the video timing generator and the first iterator stage. It maps each screen pixel (x, y) to a complex-plane coordinate (cx, cy) in Q4.12 fixed point, using a view origin and a power-of-two step. Pan/zoom commands arrive on a valid/ready handshake and take effect only at a frame boundary, so a frame is never rendered with mixed view parameters. Video sync/enable is delayed so it lines up with the iterator chain's output.

---
 rtl/mandel_view_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mandel_view_ctrl.sv
// Viewport controller: maps screen pixels to Q4.12 complex coordinates and applies pan/zoom at frame boundaries.
// Optional build macro VIEW_AUTOZOOM_EN: implicit zoom-in on every idle frame edge.
module mandel_view_ctrl #(
    parameter int          H_CENTER = 320,
    parameter int          V_CENTER = 240,
    parameter int          S_RST    = 5,
    parameter int          S_MAX    = 8,
    parameter logic [15:0] OX_RST   = 16'hF800,
    parameter int          LATENCY  = 4
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_de,
    input  logic        i_hs,
    input  logic        i_vs,
    input  logic [9:0]  i_x,
    input  logic [9:0]  i_y,
    input  logic        i_cmd_valid,
    input  logic [2:0]  i_cmd,
    output logic        o_cmd_ready,
    output logic [15:0] o_cx,
    output logic [15:0] o_cy,
    output logic        o_de,
    output logic        o_hs,
    output logic        o_vs,
    output logic        o_frame
);

    localparam int SYNC_LEN = LATENCY + 1;

    localparam logic [2:0] CMD_NOP      = 3'd0;
    localparam logic [2:0] CMD_LEFT     = 3'd1;
    localparam logic [2:0] CMD_RIGHT    = 3'd2;
    localparam logic [2:0] CMD_UP       = 3'd3;
    localparam logic [2:0] CMD_DOWN     = 3'd4;
    localparam logic [2:0] CMD_ZOOM_IN  = 3'd5;
    localparam logic [2:0] CMD_ZOOM_OUT = 3'd6;
    localparam logic [2:0] CMD_RESET    = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_APPLY = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  cmd_p_q, cmd_p_d;
    logic [15:0] ox_q, ox_d;
    logic [15:0] oy_q, oy_d;
    logic [3:0]  s_q, s_d;
    logic [15:0] cx_q, cx_d;
    logic [15:0] cy_q, cy_d;
    logic        vs_q;
    logic [SYNC_LEN-1:0][2:0] sync_q, sync_d;

    logic        frame_edge;
    logic [15:0] pan_step;
    logic [10:0] dx, dy;

    assign frame_edge = i_vs & ~vs_q;
    assign pan_step   = 16'd16 << s_q;

    // View FSM and active-register update.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d = state_q;
        cmd_p_d = cmd_p_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        s_d     = s_q;
        case (state_q)
            ST_IDLE: begin
                if (i_cmd_valid && (i_cmd != CMD_NOP)) begin
                    cmd_p_d = i_cmd;
                    state_d = ST_PEND;
                end
`ifdef VIEW_AUTOZOOM_EN
                else if (frame_edge) begin
                    cmd_p_d = (s_q == 4'd0) ? CMD_RESET : CMD_ZOOM_IN;
                    state_d = ST_APPLY;
                end
`endif
            end
            ST_PEND: begin
                if (frame_edge) begin
                    state_d = ST_APPLY;
                end
            end
            ST_APPLY: begin
                state_d = ST_IDLE;
                case (cmd_p_q)
                    CMD_LEFT:     ox_d = ox_q - pan_step;
                    CMD_RIGHT:    ox_d = ox_q + pan_step;
                    CMD_UP:       oy_d = oy_q - pan_step;
                    CMD_DOWN:     oy_d = oy_q + pan_step;
                    CMD_ZOOM_IN:  if (s_q != 4'd0) s_d = s_q - 4'd1;
                    CMD_ZOOM_OUT: if (s_q < 4'(S_MAX)) s_d = s_q + 4'd1;
                    CMD_RESET: begin
                        ox_d = OX_RST;
                        oy_d = 16'h0000;
                        s_d  = 4'(S_RST);
                    end
                    default: ;
                endcase
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pixel offsets from the screen centre are 11-bit signed, sign-extended before scaling.
    always_comb begin
        dx     = {1'b0, i_x} - 11'(H_CENTER);
        dy     = {1'b0, i_y} - 11'(V_CENTER);
        cx_d   = ox_q + ({{5{dx[10]}}, dx} << s_q);
        cy_d   = oy_q + ({{5{dy[10]}}, dy} << s_q);
        sync_d = {sync_q[SYNC_LEN-2:0], {i_de, i_hs, i_vs}};
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
        if (!i_rstn) begin
            state_q <= ST_IDLE;
            cmd_p_q <= CMD_NOP;
            ox_q    <= OX_RST;
            oy_q    <= 16'h0000;
            s_q     <= 4'(S_RST);
            cx_q    <= 16'h0000;
            cy_q    <= 16'h0000;
            vs_q    <= 1'b0;
            sync_q  <= '0;
        end else begin
            state_q <= state_d;
            cmd_p_q <= cmd_p_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            s_q     <= s_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            vs_q    <= i_vs;
            sync_q  <= sync_d;
        end
    end

    assign o_cmd_ready = (state_q == ST_IDLE);
    assign o_frame     = (state_q == ST_APPLY);
    assign o_cx        = cx_q;
    assign o_cy        = cy_q;
    assign {o_de, o_hs, o_vs} = sync_q[SYNC_LEN-1];

endmodule
